// File: rtl/npc_pc_if.sv
// Instruction-memory request channel between the fetch PC unit and imem.
// Handshake: imem_req is the request valid and pc_F is the address it carries.
// imem_ready is the memory's accept. A request transfers on any cycle where both
// are high. imem_req does not depend on imem_ready.
interface npc_pc_if;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] pc_F;

    modport master (
        output imem_req,
        output pc_F,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  pc_F,
        output imem_ready
    );
endinterface

// File: rtl/npc_pc.sv
// Fetch-stage program counter and next-PC unit for a 5-stage MIPS pipeline.
// The unit resolves branch, j/jal and jr redirects from the ID stage with
// delayed-branch timing. It drives the imem request and can hold one pending
// redirect while fetch is blocked.
module npc_pc #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          OP_W     = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            d_valid,
    input  logic [OP_W-1:0] npc_op,
    input  logic            cmpout,
    input  logic [31:0]     pc_D,
    input  logic [15:0]     imm16_D,
    input  logic [25:0]     index_D,
    input  logic [31:0]     jr_tgt_D,
    npc_pc_if.master        imem,
    output logic [31:0]     pc4_F,
    output logic            f_fire,
    output logic            redir_pend,
    output logic            pc_err,
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam logic [OP_W-1:0] OP_BR = OP_W'(1);
    localparam logic [OP_W-1:0] OP_J  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_JR = OP_W'(3);

    state_t      state, nxt_state;
    logic [31:0] pc_q, nxt_pc;
    logic [31:0] buf_q, nxt_buf;
    logic        err_q, nxt_err;

    logic        eval;
    logic        redir;
    logic [31:0] pc_D_plus4;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] jr_tgt;
    logic [31:0] tgt;

    // Target arithmetic for every redirect kind; all sums wrap modulo 2^32.
    always_comb begin
        pc_D_plus4 = pc_D + 32'd4;
        br_tgt     = pc_D_plus4 + {{14{imm16_D[15]}}, imm16_D, 2'b00};
        j_tgt      = {pc_D_plus4[31:28], index_D, 2'b00};
        jr_tgt     = {jr_tgt_D[31:2], 2'b00};
        tgt        = pc_D_plus4;
        unique case (npc_op)
            OP_BR:   tgt = br_tgt;
            OP_J:    tgt = j_tgt;
            OP_JR:   tgt = jr_tgt;
            default: tgt = pc_D_plus4;
        endcase
    end

    // Redirect decode and fetch handshake. A stalled ID instruction is not evaluated.
    always_comb begin
        eval          = d_valid & ~stall;
        redir         = eval & ((npc_op == OP_BR & cmpout) |
                                (npc_op == OP_J) | (npc_op == OP_JR));
        imem.imem_req = (state != BOOT);
        f_fire        = imem.imem_req & imem.imem_ready & ~stall;
    end

    // Next-state logic. A live redirect beats the buffered target, which beats pc+4.
    // The redirect lands at the fire that completes the delay-slot fetch.
    always_comb begin
        nxt_state = state;
        nxt_pc    = pc_q;
        nxt_buf   = buf_q;
        nxt_err   = err_q | (eval & (npc_op == OP_JR) & (jr_tgt_D[1:0] != 2'b00));
        if (f_fire) begin
            if (redir)
                nxt_pc = tgt;
            else if (state == PEND)
                nxt_pc = buf_q;
            else
                nxt_pc = pc_q + 32'd4;
            nxt_buf   = '0;
            nxt_state = RUN;
        end else if (redir) begin
            // Fetch blocked: hold pc_F and park the target (overwrites any older one).
            nxt_buf   = tgt;
            nxt_state = PEND;
        end else if (state == BOOT) begin
            nxt_state = RUN;
        end
    end

    // State registers with asynchronous reset; reset drops any pending target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            pc_q  <= RESET_PC;
            buf_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= nxt_state;
            pc_q  <= nxt_pc;
            buf_q <= nxt_buf;
            err_q <= nxt_err;
        end
    end

    // Output views of the registered state.
    always_comb begin
        imem.pc_F  = pc_q;
        pc4_F      = pc_q + 32'd4;
        redir_pend = (state == PEND);
        pc_err     = err_q;
        state_dbg  = state;
    end

endmodule

// File: tb/tb_npc_pc.sv
// Directed bench for npc_pc. Expected values are hand-computed from the
// branch/jump target rules.
module tb_npc_pc;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        d_valid;
    logic [2:0]  npc_op;
    logic        cmpout;
    logic [31:0] pc_D;
    logic [15:0] imm16_D;
    logic [25:0] index_D;
    logic [31:0] jr_tgt_D;
    logic [31:0] pc4_F;
    logic        f_fire;
    logic        redir_pend;
    logic        pc_err;
    logic [1:0]  state_dbg;

    int vectors;
    int miscompares;

    npc_pc_if imem ();

    npc_pc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .d_valid    (d_valid),
        .npc_op     (npc_op),
        .cmpout     (cmpout),
        .pc_D       (pc_D),
        .imm16_D    (imm16_D),
        .index_D    (index_D),
        .jr_tgt_D   (jr_tgt_D),
        .imem       (imem.master),
        .pc4_F      (pc4_F),
        .f_fire     (f_fire),
        .redir_pend (redir_pend),
        .pc_err     (pc_err),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        d_valid = 1'b0;
        npc_op  = 3'b000;
        cmpout  = 1'b0;
        stall   = 1'b0;
    endtask

    task automatic drive_br(input logic [31:0] pcd, input logic [15:0] imm, input logic c);
        d_valid = 1'b1;
        npc_op  = 3'b001;
        cmpout  = c;
        pc_D    = pcd;
        imm16_D = imm;
    endtask

    task automatic drive_j(input logic [31:0] pcd, input logic [25:0] idx);
        d_valid = 1'b1;
        npc_op  = 3'b010;
        pc_D    = pcd;
        index_D = idx;
    endtask

    task automatic drive_jr(input logic [31:0] rs);
        d_valid  = 1'b1;
        npc_op   = 3'b011;
        jr_tgt_D = rs;
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        rst_n           = 1'b0;
        imem.imem_ready = 1'b1;
        pc_D            = '0;
        imm16_D         = '0;
        index_D         = '0;
        jr_tgt_D        = '0;
        drive_idle();

        // reset values
        #12;
        chk("rst_pc", imem.pc_F, 32'h0000_3000);
        chk("rst_pc4", pc4_F, 32'h0000_3004);
        chk("rst_req", {31'd0, imem.imem_req}, 32'd0);
        chk("rst_pend", {31'd0, redir_pend}, 32'd0);
        chk("rst_err", {31'd0, pc_err}, 32'd0);
        chk("rst_state", {30'd0, state_dbg}, 32'd0);

        // boot: one cycle without request, then sequential fetch
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("boot_req", {31'd0, imem.imem_req}, 32'd0);
        chk("boot_fire", {31'd0, f_fire}, 32'd0);
        step();
        chk("run_req", {31'd0, imem.imem_req}, 32'd1);
        chk("run_state", {30'd0, state_dbg}, 32'd1);
        chk("seq0", imem.pc_F, 32'h0000_3000);
        chk("seq0_fire", {31'd0, f_fire}, 32'd1);
        step();
        chk("seq1", imem.pc_F, 32'h0000_3004);
        step();
        chk("seq2", imem.pc_F, 32'h0000_3008);

        // taken forward branch: 0x3010 + 4 + 16
        drive_br(32'h0000_3010, 16'h0004, 1'b1);
        step();
        chk("beq_taken", imem.pc_F, 32'h0000_3024);
        drive_idle();
        step();
        chk("after_taken", imem.pc_F, 32'h0000_3028);

        // not-taken branch falls through
        drive_br(32'h0000_3024, 16'h0004, 1'b0);
        step();
        chk("beq_not_taken", imem.pc_F, 32'h0000_302C);

        // backward branch: 0x3024 - 16
        drive_br(32'h0000_3020, 16'hFFFC, 1'b1);
        step();
        chk("beq_back", imem.pc_F, 32'h0000_3014);

        // j: {0x0, 0x0000C00, 00}
        drive_j(32'h0000_3000, 26'h0000C00);
        step();
        chk("j", imem.pc_F, 32'h0000_3000);

        // j keeps the top nibble of pc_D+4
        drive_j(32'hA000_0100, 26'h0000040);
        step();
        chk("j_region", imem.pc_F, 32'hA000_0100);

        // branch target wraps past 2^32: 0xFFFFFFFC + 8
        drive_br(32'hFFFF_FFF8, 16'h0002, 1'b1);
        step();
        chk("br_wrap", imem.pc_F, 32'h0000_0004);
        drive_idle();

        // redirect while imem not ready: buffered, pc_F held
        imem.imem_ready = 1'b0;
        drive_br(32'h0000_3010, 16'h0004, 1'b1);
        step();
        drive_idle();
        chk("pend_set", {31'd0, redir_pend}, 32'd1);
        chk("pend_state", {30'd0, state_dbg}, 32'd2);
        chk("pend_hold0", imem.pc_F, 32'h0000_0004);
        step();
        step();
        chk("pend_hold2", imem.pc_F, 32'h0000_0004);
        chk("pend_req", {31'd0, imem.imem_req}, 32'd1);
        chk("pend_nofire", {31'd0, f_fire}, 32'd0);
        imem.imem_ready = 1'b1;
        #1;
        chk("pend_fire", {31'd0, f_fire}, 32'd1);
        step();
        chk("pend_apply", imem.pc_F, 32'h0000_3024);
        chk("pend_clr", {31'd0, redir_pend}, 32'd0);

        // jr with misaligned target: low bits dropped, sticky error
        drive_jr(32'h0000_3402);
        step();
        drive_idle();
        chk("jr", imem.pc_F, 32'h0000_3400);
        chk("jr_err", {31'd0, pc_err}, 32'd1);
        step();
        chk("jr_err_sticky", {31'd0, pc_err}, 32'd1);
        chk("jr_next", imem.pc_F, 32'h0000_3404);

        // stall freezes pc_F and suppresses redirect evaluation
        drive_br(32'h0000_3010, 16'h0004, 1'b1);
        stall = 1'b1;
        step();
        step();
        chk("stall_pc", imem.pc_F, 32'h0000_3404);
        chk("stall_pend", {31'd0, redir_pend}, 32'd0);
        chk("stall_req", {31'd0, imem.imem_req}, 32'd1);
        chk("stall_fire", {31'd0, f_fire}, 32'd0);
        stall = 1'b0;
        step();
        chk("stall_release", imem.pc_F, 32'h0000_3024);
        drive_idle();
        step();
        chk("stall_once", imem.pc_F, 32'h0000_3028);

        // second redirect while pending overwrites the buffer
        imem.imem_ready = 1'b0;
        drive_br(32'h0000_3010, 16'h0004, 1'b1);
        step();
        drive_j(32'h0000_3000, 26'h0000D00);
        step();
        drive_idle();
        imem.imem_ready = 1'b1;
        step();
        chk("overwrite", imem.pc_F, 32'h0000_3400);

        // live redirect beats the buffered target on the same fire
        imem.imem_ready = 1'b0;
        drive_br(32'h0000_3010, 16'h0004, 1'b1);
        step();
        imem.imem_ready = 1'b1;
        drive_j(32'h0000_3000, 26'h0000E00);
        step();
        drive_idle();
        chk("live_wins", imem.pc_F, 32'h0000_3800);
        chk("live_wins_clr", {31'd0, redir_pend}, 32'd0);

        // asynchronous reset while pending
        imem.imem_ready = 1'b0;
        drive_br(32'h0000_3010, 16'h0004, 1'b1);
        step();
        drive_idle();
        chk("pre_rst_pend", {31'd0, redir_pend}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_pc", imem.pc_F, 32'h0000_3000);
        chk("arst_pend", {31'd0, redir_pend}, 32'd0);
        chk("arst_err", {31'd0, pc_err}, 32'd0);
        chk("arst_req", {31'd0, imem.imem_req}, 32'd0);

        // redirect during boot is buffered, then applied on the first fire
        @(negedge clk);
        rst_n           = 1'b1;
        imem.imem_ready = 1'b1;
        drive_br(32'h0000_3010, 16'h0004, 1'b1);
        step();
        drive_idle();
        chk("boot_redir_pend", {31'd0, redir_pend}, 32'd1);
        chk("boot_redir_hold", imem.pc_F, 32'h0000_3000);
        step();
        chk("boot_redir_apply", imem.pc_F, 32'h0000_3024);
        chk("boot_redir_clr", {31'd0, redir_pend}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
